// File: rtl/tx_data_buffer.sv
// -----------------------------------------------------------------------------
// tx_data_buffer
//   Transmit-side byte FIFO in front of the USB transmitter. The AHB side
//   pushes 1, 2 or 4 little-endian bytes per write strobe. The transmitter
//   pops one byte per get_tx_packet_data pulse and reads the head byte
//   combinationally on tx_packet_data.
//
// Optional feature macro: TX_BUF_STICKY_ERR_EN
//   Defined   : overflow_err / underflow_err stay set until clear or n_rst.
//   Undefined : both errors are single-cycle pulses (default build).
//
// Ports
//   clk                 system clock, rising edge
//   n_rst               asynchronous active-low reset
//   clear               synchronous flush, highest priority
//   store_tx_data       write strobe (one cycle per write)
//   tx_data[31:0]       write data, byte 0 is popped first
//   tx_size[1:0]        bytes per write: 0=1, 1=2, 2=4, 3=reserved (rejected)
//   get_tx_packet_data  pop strobe
//   tx_packet_data[7:0] head byte, 8'h00 while empty
//   buffer_occupancy    bytes held, 0..DEPTH (registered)
//   buffer_full         occupancy == DEPTH (registered)
//   buffer_empty        occupancy == 0 (registered)
//   overflow_err        a write was rejected
//   underflow_err       a pop was attempted while empty
// -----------------------------------------------------------------------------
module tx_data_buffer #(
  parameter int DEPTH = 64,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [31:0]      tx_data,
  input  logic [1:0]       tx_size,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_full,
  output logic             buffer_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             full_r;
  logic             empty_r;
  logic             ovf_r;
  logic             udf_r;

  logic [OCC_W-1:0] n_bytes_s;
  logic [OCC_W-1:0] free_s;
  logic             wr_accept_s;
  logic             wr_reject_s;
  logic             rd_accept_s;
  logic             rd_reject_s;
  logic [OCC_W-1:0] occ_next_s;
  logic             ovf_next_s;
  logic             udf_next_s;

  // Decode the write size; the reserved code maps to zero bytes.
  always_comb begin
    n_bytes_s = {OCC_W{1'b0}};
    case (tx_size)
      2'd0:    n_bytes_s = OCC_W'(1);
      2'd1:    n_bytes_s = OCC_W'(2);
      2'd2:    n_bytes_s = OCC_W'(4);
      default: n_bytes_s = {OCC_W{1'b0}};
    endcase
  end

  // Accept/reject decisions use only registered occupancy, so a same-cycle
  // pop never makes room for a write (write to a full buffer is rejected).
  always_comb begin
    free_s      = OCC_W'(DEPTH) - occ_r;
    wr_accept_s = 1'b0;
    wr_reject_s = 1'b0;
    if (store_tx_data) begin
      if ((tx_size != 2'd3) && (free_s >= n_bytes_s)) begin
        wr_accept_s = 1'b1;
      end else begin
        wr_reject_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
      wr_reject_s = 1'b0;
    end
    rd_accept_s = get_tx_packet_data & ~empty_r;
    rd_reject_s = get_tx_packet_data & empty_r;
  end

  // Next occupancy and next error state.
  always_comb begin
    occ_next_s = occ_r;
    if (wr_accept_s) begin
      occ_next_s = occ_next_s + n_bytes_s;
    end else begin
      occ_next_s = occ_next_s;
    end
    if (rd_accept_s) begin
      occ_next_s = occ_next_s - OCC_W'(1);
    end else begin
      occ_next_s = occ_next_s;
    end
`ifdef TX_BUF_STICKY_ERR_EN
    ovf_next_s = ovf_r | wr_reject_s;
    udf_next_s = udf_r | rd_reject_s;
`else
    ovf_next_s = wr_reject_s;
    udf_next_s = rd_reject_s;
`endif
  end

  // Pointers, occupancy, status flags and error flags; clear overrides all.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else if (clear) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wptr_r <= wptr_r + n_bytes_s[PTR_W-1:0];
      end
      if (rd_accept_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      occ_r   <= occ_next_s;
      full_r  <= (occ_next_s == OCC_W'(DEPTH));
      empty_r <= (occ_next_s == {OCC_W{1'b0}});
      ovf_r   <= ovf_next_s;
      udf_r   <= udf_next_s;
    end
  end

  // Byte storage, deliberately not reset; pointer arithmetic wraps naturally.
  always_ff @(posedge clk) begin
    if (wr_accept_s && !clear) begin
      for (int k = 0; k < 4; k++) begin
        if (OCC_W'(k) < n_bytes_s) begin
          mem_r[wptr_r + PTR_W'(k)] <= tx_data[8*k +: 8];
        end
      end
    end
  end

  // Head byte is combinational from registered state, forced to zero when empty.
  always_comb begin
    if (empty_r) begin
      tx_packet_data = 8'h00;
    end else begin
      tx_packet_data = mem_r[rptr_r];
    end
  end

  assign buffer_occupancy = occ_r;
  assign buffer_full      = full_r;
  assign buffer_empty     = empty_r;
  assign overflow_err     = ovf_r;
  assign underflow_err    = udf_r;

endmodule
